// File: rtl/tank_sprite_compositor.sv
// Multi-sprite compositor: NUM_SPRITES double-buffered sprite channels over a background
// colour, 2-cycle pixel pipeline (hit/addr -> ROM/palette -> RGB) and a per-frame collision flag.
module tank_sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int FRAMES = 4,
  parameter int PIX_BITS = 4,
  parameter logic [PIX_BITS-1:0] TRANSPARENT = '0,
  parameter logic [11:0] BG_RGB = 12'h000,
  localparam int ADDR_W = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int FR_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                            vga_clk,
  input  logic                            reset,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic                            blank,
  input  logic                            frame_start,
  input  logic                            wr_en,
  input  logic [SEL_W-1:0]                wr_sel,
  input  logic [9:0]                      wr_x,
  input  logic [9:0]                      wr_y,
  input  logic [FR_W-1:0]                 wr_frame,
  input  logic                            wr_flip,
  input  logic                            wr_show,
  output logic [NUM_SPRITES*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_SPRITES*PIX_BITS-1:0] rom_q,
  output logic [PIX_BITS-1:0]             pal_index,
  input  logic [3:0]                      pal_r,
  input  logic [3:0]                      pal_g,
  input  logic [3:0]                      pal_b,
  output logic [3:0]                      red,
  output logic [3:0]                      green,
  output logic [3:0]                      blue,
  output logic                            collision
);

  logic [NUM_SPRITES-1:0] opaque;

  genvar gi;
  for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_ch
    logic [9:0]      sh_x_q, sh_x_d, sh_y_q, sh_y_d, act_x_q, act_y_q;
    logic [FR_W-1:0] sh_fr_q, sh_fr_d, act_fr_q;
    logic            sh_flip_q, sh_flip_d, sh_show_q, sh_show_d;
    logic            act_flip_q, act_show_q;
    logic            wr_hit, hit_d, hit_q;
    logic [10:0]     dx, dy, x0, y0;
    logic [9:0]      lx, ly, col;

    // Out-of-range selects never match any channel, so they are dropped here.
    assign wr_hit = wr_en && (int'(wr_sel) == gi);

    always_comb begin
      sh_x_d    = sh_x_q;
      sh_y_d    = sh_y_q;
      sh_fr_d   = sh_fr_q;
      sh_flip_d = sh_flip_q;
      sh_show_d = sh_show_q;
      if (wr_hit) begin
        sh_x_d    = wr_x;
        sh_y_d    = wr_y;
        sh_fr_d   = wr_frame;
        sh_flip_d = wr_flip;
        sh_show_d = wr_show;
      end
    end

    // Active copy takes the post-write shadow so a same-cycle write is committed.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        sh_x_q     <= '0;
        sh_y_q     <= '0;
        sh_fr_q    <= '0;
        sh_flip_q  <= 1'b0;
        sh_show_q  <= 1'b0;
        act_x_q    <= '0;
        act_y_q    <= '0;
        act_fr_q   <= '0;
        act_flip_q <= 1'b0;
        act_show_q <= 1'b0;
        hit_q      <= 1'b0;
      end else begin
        sh_x_q    <= sh_x_d;
        sh_y_q    <= sh_y_d;
        sh_fr_q   <= sh_fr_d;
        sh_flip_q <= sh_flip_d;
        sh_show_q <= sh_show_d;
        if (frame_start) begin
          act_x_q    <= sh_x_d;
          act_y_q    <= sh_y_d;
          act_fr_q   <= sh_fr_d;
          act_flip_q <= sh_flip_d;
          act_show_q <= sh_show_d;
        end
        hit_q <= hit_d;
      end
    end

    // 11-bit compare so a sprite near the right/bottom edge never wraps to 0.
    assign dx    = {1'b0, DrawX};
    assign dy    = {1'b0, DrawY};
    assign x0    = {1'b0, act_x_q};
    assign y0    = {1'b0, act_y_q};
    assign hit_d = act_show_q && (dx >= x0) && (dx < x0 + 11'(SPR_W))
                   && (dy >= y0) && (dy < y0 + 11'(SPR_H));

    assign lx  = DrawX - act_x_q;
    assign ly  = DrawY - act_y_q;
    assign col = act_flip_q ? (10'(SPR_W - 1) - lx) : lx;

    assign rom_addr[gi*ADDR_W +: ADDR_W] =
      ADDR_W'(32'(act_fr_q) * (SPR_W * SPR_H) + 32'(ly) * SPR_W + 32'(col));

    assign opaque[gi] = hit_q && (rom_q[gi*PIX_BITS +: PIX_BITS] != TRANSPARENT);
  end

  logic        any_opaque, multi_opaque;
  logic        blank_q;
  logic        sticky_q, sticky_d;
  logic        coll_q;
  logic [11:0] rgb_q, rgb_d;

  // Scan from highest to lowest index so the lowest-numbered opaque channel wins.
  always_comb begin
    pal_index    = '0;
    any_opaque   = 1'b0;
    multi_opaque = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        pal_index = rom_q[i*PIX_BITS +: PIX_BITS];
        if (any_opaque) multi_opaque = 1'b1;
        any_opaque = 1'b1;
      end
    end
  end

  always_comb begin
    if (!blank_q)        rgb_d = 12'h000;
    else if (!any_opaque) rgb_d = BG_RGB;
    else                 rgb_d = {pal_r, pal_g, pal_b};
    sticky_d = sticky_q | (blank_q & multi_opaque);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q  <= 1'b0;
      rgb_q    <= 12'h000;
      sticky_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      blank_q <= blank;
      rgb_q   <= rgb_d;
      if (frame_start) begin
        coll_q   <= sticky_d;
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_d;
      end
    end
  end

  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign collision = coll_q;

endmodule

// File: tb/tb_tank_sprite_compositor.sv
// Scoreboard bench for tank_sprite_compositor: each pixel's expected colour is pushed when
// driven and popped two cycles later; collision is tracked by a frame-level model.
module tb_tank_sprite_compositor;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam logic [11:0] BG = 12'h1A2;

  logic            vga_clk = 1'b0;
  logic            reset = 1'b1;
  logic [9:0]      DrawX = '0, DrawY = '0;
  logic            blank = 1'b0, frame_start = 1'b0, wr_en = 1'b0;
  logic [1:0]      wr_sel = '0;
  logic [9:0]      wr_x = '0, wr_y = '0;
  logic [1:0]      wr_frame = '0;
  logic            wr_flip = 1'b0, wr_show = 1'b0;
  logic [N*AW-1:0] rom_addr;
  logic [N*4-1:0]  rom_q;
  logic [3:0]      pal_index, pal_r, pal_g, pal_b, red, green, blue;
  logic            collision;

  logic [3:0]  rom_const [N];
  int          m_sx [N], m_sy [N], m_ax [N], m_ay [N];
  bit          m_sshow [N], m_ashow [N];
  bit          sticky_m, coll_m, pend_m;
  logic [11:0] exp_q [$];
  int          errors = 0, checks = 0;

  always #5 vga_clk = ~vga_clk;

  tank_sprite_compositor #(.BG_RGB(BG)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y),
    .wr_frame(wr_frame), .wr_flip(wr_flip), .wr_show(wr_show), .rom_addr(rom_addr),
    .rom_q(rom_q), .pal_index(pal_index), .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
    .red(red), .green(green), .blue(blue), .collision(collision)
  );

  // Sprite ROMs: one constant index per channel, one cycle of latency.
  always @(posedge vga_clk)
    for (int i = 0; i < N; i++) rom_q[i*4 +: 4] <= rom_const[i];

  function automatic logic [11:0] pal_fn(input logic [3:0] i);
    if (i == 4'd5) return 12'hF80;
    return {i, ~i, i ^ 4'h9};
  endfunction

  assign {pal_r, pal_g, pal_b} = pal_fn(pal_index);

  function automatic bit model_hit(input int c, input int x, input int y);
    return m_ashow[c] && x >= m_ax[c] && x < m_ax[c] + 32 && y >= m_ay[c] && y < m_ay[c] + 32;
  endfunction

  task automatic tick();
    logic [11:0] e, got;
    int first, nop;
    bit rst_now, st;
    first = -1;
    nop = 0;
    for (int c = 0; c < N; c++)
      if (model_hit(c, int'(DrawX), int'(DrawY)) && rom_const[c] != 4'd0) begin
        if (first < 0) first = c;
        nop++;
      end
    if (!blank)          e = 12'h000;
    else if (first < 0)  e = BG;
    else                 e = pal_fn(rom_const[first]);
    exp_q.push_back(e);
    rst_now = reset;
    if (rst_now) begin
      for (int c = 0; c < N; c++) begin
        m_sx[c] = 0; m_sy[c] = 0; m_sshow[c] = 0;
        m_ax[c] = 0; m_ay[c] = 0; m_ashow[c] = 0;
      end
      sticky_m = 0; coll_m = 0; pend_m = 0;
    end else begin
      if (wr_en) begin
        m_sx[wr_sel] = int'(wr_x);
        m_sy[wr_sel] = int'(wr_y);
        m_sshow[wr_sel] = wr_show;
      end
      st = sticky_m | pend_m;
      if (frame_start) begin
        coll_m = st;
        sticky_m = 0;
        for (int c = 0; c < N; c++) begin
          m_ax[c] = m_sx[c]; m_ay[c] = m_sy[c]; m_ashow[c] = m_sshow[c];
        end
      end else begin
        sticky_m = st;
      end
      pend_m = blank && (nop >= 2);
    end
    @(posedge vga_clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    frame_start = 1'b0;
    got = {red, green, blue};
    if (rst_now) begin
      exp_q.delete();
      checks++;
      if (got !== 12'h000 || collision !== 1'b0) begin
        errors++;
        $display("FAIL reset_out: rgb=%h coll=%b, required rgb=000 coll=0", got, collision);
      end
    end else begin
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL rgb @t=%0t: got %h, required %h", $time, got, e);
        end
      end
      checks++;
      if (collision !== coll_m) begin
        errors++;
        $display("FAIL collision_track @t=%0t: got %b, required %b", $time, collision, coll_m);
      end
    end
  endtask

  task automatic pix(input int x, input int y, input bit b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    tick();
  endtask

  task automatic scan(input int y, input int x0, input int x1, input bit b);
    for (int x = x0; x <= x1; x++) pix(x, y, b);
  endtask

  task automatic write_spr(input int c, input int x, input int y, input int fr,
                           input bit fl, input bit sh);
    wr_en = 1'b1;
    wr_sel = 2'(c);
    wr_x = 10'(x);
    wr_y = 10'(y);
    wr_frame = 2'(fr);
    wr_flip = fl;
    wr_show = sh;
    blank = 1'b0;
    tick();
  endtask

  task automatic commit();
    frame_start = 1'b1;
    blank = 1'b0;
    tick();
  endtask

  task automatic hide_all();
    for (int c = 0; c < N; c++) write_spr(c, 0, 0, 0, 0, 0);
  endtask

  task automatic check_coll(input string name, input logic want);
    checks++;
    if (collision !== want) begin
      errors++;
      $display("FAIL %s: collision=%b, required %b", name, collision, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick();
    reset = 1'b1; tick();
    checks++;
    if (pal_index !== 4'd0) begin
      errors++;
      $display("FAIL reset_pal_index: got %0d, required 0", pal_index);
    end
    pix(10, 10, 1);
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release_out: got %h, required 000", {red, green, blue});
    end
    pix(11, 10, 1);
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_sprite();
    rom_const[0] = 4'd5; rom_const[1] = 4'd0; rom_const[2] = 4'd0; rom_const[3] = 4'd0;
    write_spr(0, 100, 50, 0, 0, 1);
    commit();
    scan(50, 96, 135, 1);
    scan(81, 98, 133, 1);
    scan(82, 98, 102, 1);
    scan(49, 98, 102, 1);
    pix(100, 50, 1);
    pix(101, 50, 1);
    checks++;
    if ({red, green, blue} !== 12'hF80) begin
      errors++;
      $display("FAIL single_topleft: got %h, required F80", {red, green, blue});
    end
    $display("test_single_sprite done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_shadow();
    write_spr(0, 200, 50, 0, 0, 1);
    scan(60, 98, 102, 1);
    scan(60, 198, 202, 1);
    commit();
    scan(60, 98, 102, 1);
    scan(60, 198, 202, 1);
    $display("test_shadow done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic check_addr(input int c, input int x, input int y, input int want);
    logic [AW-1:0] got;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = 1'b1;
    #1;
    got = rom_addr[c*AW +: AW];
    checks++;
    if (got !== AW'(want)) begin
      errors++;
      $display("FAIL rom_addr ch%0d (%0d,%0d): got %0d, required %0d", c, x, y, got, want);
    end
    tick();
  endtask

  task automatic test_flip_frame();
    write_spr(0, 300, 100, 2, 1, 1);
    write_spr(1, 400, 10, 1, 0, 1);
    commit();
    check_addr(0, 300, 100, 2*1024 + 31);
    check_addr(0, 331, 100, 2*1024 + 0);
    check_addr(0, 305, 103, 2*1024 + 3*32 + 26);
    check_addr(1, 403, 12, 1*1024 + 2*32 + 3);
    check_addr(1, 431, 41, 1*1024 + 31*32 + 31);
    $display("test_flip_frame done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_priority();
    write_spr(0, 100, 50, 0, 0, 1);
    write_spr(1, 110, 55, 0, 0, 1);
    commit();
    rom_const[0] = 4'd3; rom_const[1] = 4'd7;
    scan(60, 105, 143, 1);
    rom_const[0] = 4'd0; rom_const[1] = 4'd7;
    scan(60, 105, 143, 1);
    rom_const[0] = 4'd0; rom_const[1] = 4'd0;
    scan(60, 105, 143, 1);
    $display("test_priority done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_collision();
    rom_const[0] = 4'd3; rom_const[1] = 4'd7;
    write_spr(0, 100, 50, 0, 0, 1);
    write_spr(1, 131, 81, 0, 0, 1);
    commit();
    commit();
    check_coll("coll_cleared", 1'b0);
    scan(81, 130, 132, 1);
    commit();
    check_coll("coll_set", 1'b1);
    write_spr(1, 300, 81, 0, 0, 1);
    commit();
    scan(81, 130, 132, 1);
    commit();
    check_coll("coll_separated", 1'b0);
    write_spr(1, 131, 81, 0, 0, 1);
    commit();
    scan(81, 130, 132, 0);
    commit();
    check_coll("coll_blanked_overlap", 1'b0);
    $display("test_collision done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_edge_reset();
    hide_all();
    rom_const[2] = 4'd9;
    write_spr(2, 620, 200, 0, 0, 1);
    commit();
    scan(200, 615, 639, 1);
    scan(200, 0, 12, 1);
    scan(231, 636, 639, 1);
    scan(232, 636, 639, 1);
    DrawX = 10'd630; DrawY = 10'd205; blank = 1'b1;
    reset = 1'b1;
    tick();
    scan(205, 625, 639, 1);
    write_spr(2, 620, 200, 0, 0, 1);
    scan(205, 625, 639, 1);
    commit();
    scan(205, 618, 639, 1);
    $display("test_edge_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    for (int batch = 0; batch < 3; batch++) begin
      for (int c = 0; c < N; c++) begin
        rom_const[c] = 4'($urandom_range(0, 15));
        write_spr(c, $urandom_range(100, 300), $urandom_range(100, 200), 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      commit();
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 49) == 0) frame_start = 1'b1;
        pix($urandom_range(80, 340), $urandom_range(90, 240), 1'($urandom_range(0, 7) != 0));
      end
    end
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    for (int c = 0; c < N; c++) rom_const[c] = 4'd0;
    test_reset();
    test_single_sprite();
    test_shadow();
    test_flip_frame();
    test_priority();
    test_collision();
    test_edge_reset();
    test_back_to_back();
    pix(0, 0, 0);
    pix(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tank_sprite_compositor.md
# tank_sprite_compositor

Parametrised multi-sprite renderer for the VGA path. It composites NUM_SPRITES independently positioned, optionally mirrored, multi-frame sprites over a fixed background colour. Per-pixel RGB is registered, with sprite registers double-buffered per video frame and a per-frame opaque-overlap (collision) flag. It sits between the VGA controller (DrawX/DrawY/blank) and the DAC pins, and drives external sprite ROMs and a shared palette.

## Interface
- NUM_SPRITES, 4: sprite channels; channel 0 has highest priority.
- SPR_W, 32: sprite width in pixels; power of two.
- SPR_H, 32: sprite height in pixels; power of two.
- FRAMES, 4: animation frames per sprite ROM; power of two.
- PIX_BITS, 4: palette index width.
- TRANSPARENT, 0: palette index treated as see-through.
- BG_RGB, 12'h000: background colour {r,g,b}.
- ADDR_W, derived: log2(FRAMES*SPR_W*SPR_H).

Ports:
- vga_clk  in  1  pixel clock; only clock.
- reset  in  1  synchronous, active-high.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  1 = active video, 0 = blanking.
- frame_start  in  1  one-cycle pulse once per frame, during vertical blanking.
- wr_en  in  1  shadow-register write strobe.
- wr_sel  in  log2(NUM_SPRITES)  channel written.
- wr_x, wr_y  in  10 each  sprite top-left position.
- wr_frame  in  log2(FRAMES)  animation frame.
- wr_flip  in  1  horizontal mirror.
- wr_show  in  1  sprite visible.
- rom_addr  out  NUM_SPRITES*ADDR_W  per-channel ROM address, channel i at bits [i*ADDR_W +: ADDR_W].
- rom_q  in  NUM_SPRITES*PIX_BITS  per-channel ROM data, 1-cycle synchronous latency.
- pal_index  out  PIX_BITS  palette lookup index.
- pal_r, pal_g, pal_b  in  4 each  palette colour, combinational from pal_index.
- red, green, blue  out  4 each  registered pixel colour.
- collision  out  1  previous frame contained a pixel where two or more shown sprites were opaque.

## Operation
- Shadow registers: wr_en writes {x,y,frame,flip,show} of channel wr_sel; wr_sel >= NUM_SPRITES is ignored.
- Active registers: copied from shadow on frame_start. A write and frame_start in the same cycle commit the newly written value.
- Only active registers affect rendering, so no tearing mid-frame.
- Hit test per channel, using 11-bit arithmetic with no wrap: show && DrawX >= x && DrawX < x+SPR_W && DrawY >= y && DrawY < y+SPR_H.
- Sprites extending past 639/479 are clipped naturally.
- Local coordinates: lx = DrawX-x, ly = DrawY-y. Column is SPR_W-1-lx when flip=1, else lx.
- Address: rom_addr_i = frame*SPR_W*SPR_H + ly*SPR_W + col, truncated to ADDR_W. It is driven on every cycle, hit or not.
- Opaque for channel i means hit_i registered (stage 1) && rom_q_i != TRANSPARENT.
- pal_index is the rom_q of the lowest-numbered opaque channel; 0 if none.
- Output select: blank=0 gives 0; no opaque channel gives BG_RGB; otherwise pal_r/g/b.
- Collision: a sticky flag sets when at least two channels are opaque while stage-1 blank=1. On frame_start, collision <= sticky (including any set in that same cycle) and sticky clears.

## Timing
- Stage 0 (cycle n): DrawX/DrawY/blank sampled; rom_addr combinational; hit and blank registered.
- Stage 1 (n+1): rom_q valid, priority select, palette lookup.
- Stage 2 (n+2): red/green/blue registered.
- Latency DrawX/DrawY -> RGB is exactly 2 cycles. Throughput is 1 pixel per cycle, no stalls.
- Reset: red/green/blue = 0, collision = 0, sticky = 0, pal_index = 0.
- Reset also clears all shadow and active registers to 0 (show = 0), and clears pipeline valid/hit/blank.
- The first two cycles after reset release output 0.
- Reset asserted mid-frame takes effect at the next edge and overrides frame_start and wr_en.

## Test plan
- Single sprite: write ch0 x=100, y=50, show=1, then pulse frame_start. ROM returns index 5 inside the box, and palette 5 = 12'hF80. Required: RGB = F,8,0 at DrawX 100..131 / DrawY 50..81, delayed 2 cycles; BG_RGB at DrawX 99 and 132.
- Shadow buffering: write x=200 mid-frame without frame_start. Required: the sprite stays at x=100 until after the next frame_start, then moves to x=200.
- Flip/frame: frame=2, flip=1, pixel (x,y). Required: rom_addr = 2*1024 + 31 at the sprite's top-left pixel, and 2*1024 + 0 at its top-right pixel.
- Priority/transparency: ch0 and ch1 overlap. ch0 returns index 3 gives palette 3. ch0 returns TRANSPARENT with ch1 returning 7 gives palette 7. Both transparent gives BG_RGB.
- Collision: two opaque sprites overlap at one pixel during blank=1. Required: collision=1 after the next frame_start, and 0 after the following frame_start once the sprites are separated. An overlap only while blank=0 never sets it.
- Edge/reset: sprite at x=620 is clipped at 639 with no wrap to x=0. Asserting reset mid-line gives RGB = 0 and collision = 0 the next cycle, with sprites hidden until rewritten and committed.
